alarm_trigger: RTL and testbench
================================

# alarm_trigger

Consumer side of the alarm-time registers: compares the running clock time against the programmed alarm time on every 1 Hz tick and runs the ring/snooze/stop state machine that drives the buzzer. It sits between the alarm-setting block (source of `alarm_*`), the timekeeping counter (source of `cur_*`) and the buzzer/LED outputs.

## Interface
Parameters:
- `RING_SECS`, default 60: ticks a ring lasts before automatic silence (1..65535).
- `SNOOZE_SECS`, default 300: snooze length in ticks (1..65535).
- `MAX_SNOOZES`, default 3: snoozes allowed per alarm event (0..3).

Ports:
- `CLK`  in  1: system clock; all logic rises on posedge.
- `RESET`  in  1: reset, synchronous, active-low.
- `TICK`  in  1: one-CLK-wide 1 Hz strobe from the timekeeper.
- `ENABLE`  in  1: alarm arm switch (level).
- `SNOOZE`  in  1: snooze button, active-high level, synchronised upstream.
- `STOP`  in  1: stop button, active-high level, synchronised upstream.
- `cur_seconds`, `cur_minutes`, `cur_hours`  in  8 each: current time, binary.
- `alarm_seconds`, `alarm_minutes`, `alarm_hours`  in  8 each: programmed alarm time, binary.
- `armed`  out  1: high in ARMED.
- `ringing`  out  1: high in RINGING.
- `snoozing`  out  1: high in SNOOZED.
- `buzz`  out  1: square wave while ringing.
- `snoozes_used`  out  2: snoozes consumed in the current event.
- `remaining`  out  16: ticks left in the current RINGING or SNOOZED period, 0 otherwise.

## Operation
- States: IDLE, ARMED, RINGING, SNOOZED. Outputs are registered and decoded from state.
- Edge detect: `snz_edge` = SNOOZE & ~snz_q; `stp_edge` = STOP & ~stp_q. `snz_q` and `stp_q` register the button levels every cycle. Level holds never retrigger.
- `match` = TICK && all three `cur_*` == `alarm_*`, as a full 8-bit compare on each field. Out-of-range alarm values (e.g. seconds = 60) are compared as-is and therefore never match.
- Priority, evaluated each cycle: RESET, then ~ENABLE, then `stp_edge`, then `snz_edge`, then TICK-driven events.
- IDLE: ENABLE=1 moves to ARMED.
- ARMED: on `match`, move to RINGING, set `remaining` to RING_SECS, clear `snoozes_used`, clear `buzz`.
- RINGING:
  - `stp_edge` moves to ARMED.
  - `snz_edge` with `snoozes_used` < MAX_SNOOZES moves to SNOOZED, sets `remaining` to SNOOZE_SECS and increments `snoozes_used`. When the limit is reached, `snz_edge` is ignored.
  - On TICK, toggle `buzz`. If `remaining` == 1, move to ARMED; otherwise decrement `remaining`.
- SNOOZED:
  - `stp_edge` moves to ARMED.
  - On TICK, if `remaining` == 1, move to RINGING with `remaining` = RING_SECS and `buzz` = 0; otherwise decrement.
  - `snz_edge` is ignored.
- ENABLE=0 in any state moves to IDLE on the next edge and abandons the event. `snoozes_used` keeps its value until the next match.
- Entering ARMED or IDLE forces `remaining` to 0 and `buzz` to 0.
- After a stop or timeout, re-triggering needs a fresh `match`. The time advances every tick, so the next match is 24 h later.

## Timing
- Reset (RESET=0 at a posedge):
  - State goes to IDLE.
  - `armed`, `ringing`, `snoozing` and `buzz` go to 0; `snoozes_used` and `remaining` go to 0.
  - `snz_q` and `stp_q` go to 0, so a button held through reset produces one edge after release of reset. That edge is ignored unless the block is in RINGING or SNOOZED.
- Reset mid-ring or mid-snooze silences the buzzer on the same edge.
- Match latency: `match` sampled at edge N gives `ringing`=1 after edge N. `buzz` first goes to 1 on the next TICK after entry.
- Button latency: a press visible at edge N acts on edge N, since edge detect and transition share the cycle. Outputs change after edge N.
- Simultaneous events:
  - `stp_edge` and `snz_edge` in the same cycle: stop wins.
  - `snz_edge` on the final TICK of a ring: snooze wins.
  - `stp_edge` on a TICK in SNOOZED: stop wins, and no return to RINGING occurs.
- `remaining` is a 16-bit width and counts down to 1, never 0, while active.

## Test plan
- Reset: RESET=0 for 2 cycles with SNOOZE=STOP=1 -> all outputs 0, state IDLE. Release with ENABLE=1 -> `armed`=1 one cycle later; a button edge in ARMED has no effect.
- Match: alarm 07:30:00, ENABLE=1, `cur` stepped 07:29:58 -> 07:30:00 on TICKs -> `ringing`=1 the cycle after the 07:30:00 tick, `remaining`=60. `buzz` toggles 1,0,1 on the following ticks. After 60 ticks, `armed`=1 and `buzz`=0.
- Snooze limit: with RING_SECS=5 and SNOOZE_SECS=3, press SNOOZE during each ring -> `snoozing` for 3 ticks, then `ringing` again. This repeats for `snoozes_used`=1,2,3. The 4th press is ignored, and the ring times out to ARMED after 5 ticks.
- Stop: press STOP during RINGING and again in a separate event during SNOOZED -> `armed`=1 next cycle, `remaining`=0. Holding STOP for 10 cycles gives exactly one transition.
- Simultaneous: SNOOZE and STOP rise in the same cycle -> ARMED. SNOOZE rising on the final ring tick -> SNOOZED with `remaining`=3.
- Disable and invalid time: ENABLE=0 mid-ring -> IDLE next cycle, `ringing`=0. Alarm seconds = 60 with `cur` sweeping 00..59 -> never rings.

Source files
------------

// File: rtl/alarm_trigger_if.sv
// Signal bundle between the alarm trigger and its neighbours: clock time and
// alarm time in, button/arm levels in, ring status and buzzer drive out.
interface alarm_trigger_if;
  logic        TICK;
  logic        ENABLE;
  logic        SNOOZE;
  logic        STOP;
  logic [7:0]  cur_seconds;
  logic [7:0]  cur_minutes;
  logic [7:0]  cur_hours;
  logic [7:0]  alarm_seconds;
  logic [7:0]  alarm_minutes;
  logic [7:0]  alarm_hours;
  logic        armed;
  logic        ringing;
  logic        snoozing;
  logic        buzz;
  logic [1:0]  snoozes_used;
  logic [15:0] remaining;

  // Time sources, switches and buttons drive the trigger.
  modport master (
    output TICK, ENABLE, SNOOZE, STOP,
    output cur_seconds, cur_minutes, cur_hours,
    output alarm_seconds, alarm_minutes, alarm_hours,
    input  armed, ringing, snoozing, buzz, snoozes_used, remaining
  );

  // The trigger itself.
  modport slave (
    input  TICK, ENABLE, SNOOZE, STOP,
    input  cur_seconds, cur_minutes, cur_hours,
    input  alarm_seconds, alarm_minutes, alarm_hours,
    output armed, ringing, snoozing, buzz, snoozes_used, remaining
  );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm trigger: compares clock time with alarm time on each 1 Hz tick and
// runs the IDLE/ARMED/RINGING/SNOOZED machine that drives the buzzer.
module alarm_trigger #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZES = 3
) (
  input  logic           CLK,
  input  logic           RESET,
  alarm_trigger_if.slave bus
);

  localparam logic [15:0] RING_LEN  = RING_SECS[15:0];
  localparam logic [15:0] SNZ_LEN   = SNOOZE_SECS[15:0];
  localparam logic [1:0]  SNZ_LIMIT = MAX_SNOOZES[1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RINGING,
    S_SNOOZED
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_snz_q;
  logic        r_stp_q;
  logic        r_buzz;
  logic        w_buzz_nxt;
  logic [1:0]  r_used;
  logic [1:0]  w_used_nxt;
  logic [15:0] r_rem;
  logic [15:0] w_rem_nxt;

  logic        w_snz_edge;
  logic        w_stp_edge;
  logic        w_match;

  // Buttons act only on their rising edge; a held level never retriggers.
  assign w_snz_edge = bus.SNOOZE & ~r_snz_q;
  assign w_stp_edge = bus.STOP & ~r_stp_q;

  // Full 8-bit compare per field, so out-of-range alarm values never match.
  assign w_match = bus.TICK
                && (bus.cur_seconds == bus.alarm_seconds)
                && (bus.cur_minutes == bus.alarm_minutes)
                && (bus.cur_hours   == bus.alarm_hours);

  // State, counters and button history; reset is synchronous.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!RESET) begin
      r_state <= S_IDLE;
      r_snz_q <= 1'b0;
      r_stp_q <= 1'b0;
      r_buzz  <= 1'b0;
      r_used  <= 2'd0;
      r_rem   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_snz_q <= bus.SNOOZE;
      r_stp_q <= bus.STOP;
      r_buzz  <= w_buzz_nxt;
      r_used  <= w_used_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // Next state and next counter values: disarm, stop, snooze, then tick events.
  always_comb begin
    // NOTE: hold values are assigned first so no branch can infer a latch.
    w_state_nxt = r_state;
    w_buzz_nxt  = r_buzz;
    w_used_nxt  = r_used;
    w_rem_nxt   = r_rem;

    if (!bus.ENABLE) begin
      // Abandon the event; the snooze count stays visible until the next match.
      w_state_nxt = S_IDLE;
      w_buzz_nxt  = 1'b0;
      w_rem_nxt   = 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ARMED;
          w_buzz_nxt  = 1'b0;
          w_rem_nxt   = 16'd0;
        end

        S_ARMED: begin
          if (w_match) begin
            w_state_nxt = S_RINGING;
            w_rem_nxt   = RING_LEN;
            w_used_nxt  = 2'd0;
            w_buzz_nxt  = 1'b0;
          end
        end

        S_RINGING: begin
          if (w_stp_edge) begin
            w_state_nxt = S_ARMED;
            w_buzz_nxt  = 1'b0;
            w_rem_nxt   = 16'd0;
          end else if (w_snz_edge && (r_used < SNZ_LIMIT)) begin
            // Snooze beats the final tick of a ring.
            w_state_nxt = S_SNOOZED;
            w_rem_nxt   = SNZ_LEN;
            w_used_nxt  = r_used + 2'd1;
            w_buzz_nxt  = 1'b0;
          end else if (bus.TICK) begin
            if (r_rem == 16'd1) begin
              w_state_nxt = S_ARMED;
              w_buzz_nxt  = 1'b0;
              w_rem_nxt   = 16'd0;
            end else begin
              w_buzz_nxt  = ~r_buzz;
              w_rem_nxt   = r_rem - 16'd1;
            end
          end
        end

        S_SNOOZED: begin
          if (w_stp_edge) begin
            w_state_nxt = S_ARMED;
            w_buzz_nxt  = 1'b0;
            w_rem_nxt   = 16'd0;
          end else if (bus.TICK) begin
            if (r_rem == 16'd1) begin
              w_state_nxt = S_RINGING;
              w_rem_nxt   = RING_LEN;
              w_buzz_nxt  = 1'b0;
            end else begin
              w_rem_nxt   = r_rem - 16'd1;
            end
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_buzz_nxt  = 1'b0;
          w_rem_nxt   = 16'd0;
        end
      endcase
    end
  end

  // Status flags decode straight from the state register.
  assign bus.armed        = (r_state == S_ARMED);
  assign bus.ringing      = (r_state == S_RINGING);
  assign bus.snoozing     = (r_state == S_SNOOZED);
  assign bus.buzz         = r_buzz;
  assign bus.snoozes_used = r_used;
  assign bus.remaining    = r_rem;

endmodule

// File: tb/tb_alarm_trigger.sv
// Bench for alarm_trigger: a short-period instance (ring 5, snooze 3) and a
// default instance share stimulus; a vector table, directed sequences and a
// random run are compared against an elapsed-time reference model.
module tb_alarm_trigger;

  logic       CLK = 1'b0;
  logic       rst_n, en, tick, snz, stp;
  logic [7:0] cur_h, cur_m, cur_s, al_h, al_m, al_s;

  int n_checks = 0;
  int n_err    = 0;

  always #5 CLK = ~CLK;

  alarm_trigger_if bus_small();
  alarm_trigger_if bus_def();

  assign bus_small.TICK = tick;          assign bus_def.TICK = tick;
  assign bus_small.ENABLE = en;          assign bus_def.ENABLE = en;
  assign bus_small.SNOOZE = snz;         assign bus_def.SNOOZE = snz;
  assign bus_small.STOP = stp;           assign bus_def.STOP = stp;
  assign bus_small.cur_seconds = cur_s;  assign bus_def.cur_seconds = cur_s;
  assign bus_small.cur_minutes = cur_m;  assign bus_def.cur_minutes = cur_m;
  assign bus_small.cur_hours = cur_h;    assign bus_def.cur_hours = cur_h;
  assign bus_small.alarm_seconds = al_s; assign bus_def.alarm_seconds = al_s;
  assign bus_small.alarm_minutes = al_m; assign bus_def.alarm_minutes = al_m;
  assign bus_small.alarm_hours = al_h;   assign bus_def.alarm_hours = al_h;

  alarm_trigger #(.RING_SECS(5), .SNOOZE_SECS(3), .MAX_SNOOZES(3)) u_small (
    .CLK(CLK), .RESET(rst_n), .bus(bus_small)
  );
  alarm_trigger u_def (
    .CLK(CLK), .RESET(rst_n), .bus(bus_def)
  );

  // {armed, ringing, snoozing, buzz, snoozes_used[1:0], remaining[15:0]}
  logic [21:0] act_small, act_def;
  assign act_small = {bus_small.armed, bus_small.ringing, bus_small.snoozing,
                      bus_small.buzz, bus_small.snoozes_used, bus_small.remaining};
  assign act_def   = {bus_def.armed, bus_def.ringing, bus_def.snoozing,
                      bus_def.buzz, bus_def.snoozes_used, bus_def.remaining};

  // Reference model: mode 0 off, 1 waiting, 2 ringing, 3 snoozed; the
  // period is tracked as elapsed ticks against its length.
  typedef struct {
    int mode;
    int elapsed;
    int len;
    int used;
    bit p_snz;
    bit p_stp;
  } mdl_t;

  mdl_t m [2];

  function automatic mdl_t mstep(mdl_t s, int ring, int snzl, int maxs);
    mdl_t n;
    bit   se, te, hit;
    n   = s;
    se  = snz && !s.p_snz;
    te  = stp && !s.p_stp;
    hit = tick && (cur_h == al_h) && (cur_m == al_m) && (cur_s == al_s);
    n.p_snz = snz;
    n.p_stp = stp;
    if (!rst_n) begin
      n = '{default: 0};
      return n;
    end
    if (!en) begin
      n.mode = 0; n.len = 0; n.elapsed = 0;
      return n;
    end
    case (s.mode)
      0: n.mode = 1;
      1: if (hit) begin
           n.mode = 2; n.len = ring; n.elapsed = 0; n.used = 0;
         end
      2: if (te) begin
           n.mode = 1; n.len = 0; n.elapsed = 0;
         end else if (se && s.used < maxs) begin
           n.mode = 3; n.len = snzl; n.elapsed = 0; n.used = s.used + 1;
         end else if (tick) begin
           n.elapsed = s.elapsed + 1;
           if (n.elapsed == s.len) begin
             n.mode = 1; n.len = 0; n.elapsed = 0;
           end
         end
      3: if (te) begin
           n.mode = 1; n.len = 0; n.elapsed = 0;
         end else if (tick) begin
           n.elapsed = s.elapsed + 1;
           if (n.elapsed == s.len) begin
             n.mode = 2; n.len = ring; n.elapsed = 0;
           end
         end
      default: n.mode = 0;
    endcase
    return n;
  endfunction

  function automatic logic [21:0] mexp(mdl_t s);
    logic [15:0] rem;
    logic        bz;
    rem = (s.mode >= 2) ? 16'(s.len - s.elapsed) : 16'd0;
    bz  = (s.mode == 2) && (s.elapsed % 2 == 1);
    return {s.mode == 1, s.mode == 2, s.mode == 3, bz, 2'(s.used), rem};
  endfunction

  function automatic logic [21:0] pk(bit a, bit r, bit z, bit b,
                                     logic [1:0] u, logic [15:0] rem);
    return {a, r, z, b, u, rem};
  endfunction

  task automatic check(input string name, input logic [21:0] act,
                       input logic [21:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%06h expected 0x%06h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: model advances on the edge, both DUTs are compared 1 ns later.
  task automatic cycle();
    @(posedge CLK);
    m[0] = mstep(m[0], 5, 3, 3);
    m[1] = mstep(m[1], 60, 300, 3);
    #1;
    check("small_model", act_small, mexp(m[0]));
    check("def_model", act_def, mexp(m[1]));
  endtask

  task automatic set_hms(input int h, input int mi, input int s);
    cur_h = 8'(h); cur_m = 8'(mi); cur_s = 8'(s);
  endtask

  task automatic tick_once();
    tick = 1'b1; cycle();
    tick = 1'b0; cycle();
  endtask

  task automatic restart();
    rst_n = 1'b0; en = 1'b1; tick = 1'b0; snz = 1'b0; stp = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    check("restart_armed", {20'd0, bus_small.armed, bus_def.armed}, 22'd3);
  endtask

  // Per-cycle vector: ts selects 07:29:59 / 07:30:00 / 07:30:01.
  typedef struct {
    bit          r, e, t, sn, st;
    int          ts;
    logic [21:0] exp;
  } vec_t;

  function automatic vec_t mk(bit r, bit e, bit t, bit sn, bit st, int ts,
                              logic [21:0] exp);
    vec_t v;
    v.r = r; v.e = e; v.t = t; v.sn = sn; v.st = st; v.ts = ts; v.exp = exp;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    logic [21:0] z0, arm, r5;
    z0  = pk(0, 0, 0, 0, 2'd0, 16'd0);
    arm = pk(1, 0, 0, 0, 2'd0, 16'd0);
    r5  = pk(0, 1, 0, 0, 2'd0, 16'd5);
    m[0] = '{default: 0};
    m[1] = '{default: 0};
    al_h = 8'd7; al_m = 8'd30; al_s = 8'd0;
    rst_n = 1'b0; en = 1'b0; tick = 1'b0; snz = 1'b0; stp = 1'b0;
    set_hms(7, 29, 59);

    // Reset with buttons held, release, ring, stop, snooze, disable, reset.
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, z0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, z0));
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, arm));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, arm));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, arm));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, arm));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, arm));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, r5));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2, r5));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2, pk(0, 1, 0, 1, 2'd0, 16'd4)));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2, pk(0, 1, 0, 0, 2'd0, 16'd3)));
    tbl.push_back(mk(1, 1, 0, 1, 1, 2, arm));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2, arm));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, r5));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2, pk(0, 1, 0, 1, 2'd0, 16'd4)));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2, pk(0, 1, 0, 0, 2'd0, 16'd3)));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2, pk(0, 1, 0, 1, 2'd0, 16'd2)));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2, pk(0, 1, 0, 0, 2'd0, 16'd1)));
    tbl.push_back(mk(1, 1, 1, 1, 0, 2, pk(0, 0, 1, 0, 2'd1, 16'd3)));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2, pk(0, 0, 1, 0, 2'd1, 16'd2)));
    tbl.push_back(mk(1, 1, 1, 0, 1, 2, pk(1, 0, 0, 0, 2'd1, 16'd0)));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2, pk(1, 0, 0, 0, 2'd1, 16'd0)));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, r5));
    tbl.push_back(mk(1, 1, 0, 1, 0, 2, pk(0, 0, 1, 0, 2'd1, 16'd3)));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2, pk(0, 0, 1, 0, 2'd1, 16'd2)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2, pk(0, 0, 0, 0, 2'd1, 16'd0)));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, pk(0, 0, 0, 0, 2'd1, 16'd0)));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2, pk(1, 0, 0, 0, 2'd1, 16'd0)));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, r5));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2, pk(0, 1, 0, 1, 2'd0, 16'd4)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2, z0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2, arm));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, r5));
    tbl.push_back(mk(1, 1, 1, 0, 0, 2, pk(0, 1, 0, 1, 2'd0, 16'd4)));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2, z0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2, arm));

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].r; en = tbl[i].e; tick = tbl[i].t;
      snz = tbl[i].sn; stp = tbl[i].st;
      case (tbl[i].ts)
        0:       set_hms(7, 29, 59);
        1:       set_hms(7, 30, 0);
        default: set_hms(7, 30, 1);
      endcase
      cycle();
      check($sformatf("vec%0d", i), act_small, tbl[i].exp);
    end

    // Match on the default instance: 60-tick ring with toggling buzzer.
    restart();
    set_hms(7, 29, 58); tick_once();
    set_hms(7, 29, 59); tick_once();
    set_hms(7, 30, 0); tick = 1'b1; cycle(); tick = 1'b0;
    set_hms(7, 30, 1);
    check("match_ring", act_def, pk(0, 1, 0, 0, 2'd0, 16'd60));
    for (int k = 1; k <= 3; k++) begin
      tick_once();
      check($sformatf("buzz_tick%0d", k), 22'(bus_def.buzz), 22'(k % 2));
    end
    for (int k = 4; k <= 59; k++) tick_once();
    check("ring_last", act_def, pk(0, 1, 0, 1, 2'd0, 16'd1));
    tick_once();
    check("ring_timeout", act_def, arm);

    // Snooze limit on the short instance.
    restart();
    set_hms(7, 30, 0); tick = 1'b1; cycle(); tick = 1'b0;
    set_hms(7, 30, 1);
    check("lim_ring", act_small, r5);
    for (int k = 1; k <= 3; k++) begin
      snz = 1'b1; cycle(); snz = 1'b0; cycle();
      check($sformatf("lim_snz%0d", k), act_small, pk(0, 0, 1, 0, 2'(k), 16'd3));
      tick_once(); tick_once();
      check($sformatf("lim_snz%0d_end", k), act_small, pk(0, 0, 1, 0, 2'(k), 16'd1));
      tick_once();
      check($sformatf("lim_back%0d", k), act_small, pk(0, 1, 0, 0, 2'(k), 16'd5));
    end
    snz = 1'b1; cycle(); snz = 1'b0; cycle();
    check("lim_4th_ignored", act_small, pk(0, 1, 0, 0, 2'd3, 16'd5));
    for (int k = 0; k < 4; k++) tick_once();
    check("lim_last", act_small, pk(0, 1, 0, 0, 2'd3, 16'd1));
    tick_once();
    check("lim_timeout", act_small, pk(1, 0, 0, 0, 2'd3, 16'd0));

    // Stop in RINGING, held for 10 cycles; a fresh match mid-hold still rings.
    restart();
    set_hms(7, 30, 0); tick = 1'b1; cycle(); tick = 1'b0;
    set_hms(7, 30, 1);
    stp = 1'b1; cycle();
    check("stop_ring", act_small, arm);
    for (int i = 1; i < 10; i++) begin
      tick = (i == 4);
      if (i == 4) set_hms(7, 30, 0); else set_hms(7, 30, 1);
      cycle();
      check($sformatf("stop_hold%0d", i), 22'(bus_small.ringing), 22'(i >= 4));
    end
    tick = 1'b0; stp = 1'b0; cycle();
    snz = 1'b1; cycle(); snz = 1'b0;
    check("stop_pre_snz", act_small, pk(0, 0, 1, 0, 2'd1, 16'd3));
    stp = 1'b1; cycle(); stp = 1'b0;
    check("stop_snoozed", act_small, pk(1, 0, 0, 0, 2'd1, 16'd0));

    // Out-of-range alarm seconds never match.
    restart();
    al_s = 8'd60;
    for (int s = 0; s < 60; s++) begin
      set_hms(7, 30, s);
      tick_once();
      check($sformatf("bad_alarm_s%0d", s),
            {20'd0, bus_small.ringing, bus_def.ringing}, 22'd0);
    end
    al_s = 8'd0;

    // Random run against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      en    = ($urandom_range(0, 149) != 0);
      tick  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0)  snz = ~snz;
      if ($urandom_range(0, 39) == 0) stp = ~stp;
      if ($urandom_range(0, 3) == 0) set_hms(7, 30, 0);
      else set_hms(7, 30, int'($urandom_range(1, 59)));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
